// File: rtl/store_pkt_hdr.sv
// Output-queue packet store: moves each admitted packet from the input FIFO into its queue's
// circular SRAM region. Define STORE_PKT_HDR_WORD_EN to prepend a length header word.
module store_pkt_hdr #(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned NUM_OUTPUT_QUEUES = 8,
    parameter int unsigned NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
    parameter int unsigned SRAM_ADDR_WIDTH   = 19,
    parameter int unsigned PKT_LEN_WIDTH     = 11,
    parameter int unsigned PKT_WORDS_WIDTH   = PKT_LEN_WIDTH - $clog2(CTRL_WIDTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             dst_oq_avail,
    input  logic [NUM_OQ_WIDTH-1:0]          parsed_dst_oq,
    input  logic [PKT_LEN_WIDTH-1:0]         parsed_pkt_byte_len,
    input  logic [PKT_WORDS_WIDTH-1:0]       parsed_pkt_word_len,
    output logic                             rd_dst_oq,
    output logic [NUM_OQ_WIDTH-1:0]          dst_oq,
    output logic                             rd_dst_addr,
    input  logic [SRAM_ADDR_WIDTH-1:0]       dst_oq_wr_addr,
    input  logic [SRAM_ADDR_WIDTH-1:0]       dst_oq_low_addr,
    input  logic [SRAM_ADDR_WIDTH-1:0]       dst_oq_high_addr,
    input  logic [SRAM_ADDR_WIDTH:0]         dst_oq_words_free,
    output logic [SRAM_ADDR_WIDTH-1:0]       dst_oq_wr_addr_new,
    output logic                             pkt_stored,
    output logic                             pkt_dropped,
    output logic                             pkt_len_err,
    output logic [PKT_WORDS_WIDTH:0]         stored_pkt_word_length,
    output logic [SRAM_ADDR_WIDTH-1:0]       wr_0_addr,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0] wr_0_data,
    output logic                             wr_0_req,
    input  logic                             wr_0_ack,
    output logic                             input_fifo_rd_en,
    input  logic                             input_fifo_empty,
    input  logic [DATA_WIDTH-1:0]            input_fifo_data_out,
    input  logic [CTRL_WIDTH-1:0]            input_fifo_ctrl_out
);

    localparam int unsigned AW = SRAM_ADDR_WIDTH;
    localparam int unsigned WW = PKT_WORDS_WIDTH + 1;
`ifdef STORE_PKT_HDR_WORD_EN
    localparam int unsigned HDR_WORDS = 1;
`else
    localparam int unsigned HDR_WORDS = 0;
`endif

    typedef enum logic [2:0] {
        StIdle, StReadAddr, StLatch, StMove, StWaitData, StTail,
`ifdef STORE_PKT_HDR_WORD_EN
        StHdr,
`endif
        StDrop
    } state_e;

    state_e                     state_q;
    logic [PKT_WORDS_WIDTH-1:0] word_len_q;
    logic [AW-1:0]              lo_q, hi_q, next_addr_q;
    logic [WW-1:0]              word_cnt_q;
    logic                       prev_ctrl_zero_q;

    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] a, input logic [AW-1:0] lo,
                                           input logic [AW-1:0] hi);
        return (a >= hi) ? lo : a + AW'(1);
    endfunction

    logic          pop, eop, acked, admit;
    logic [AW:0]   need;
    logic [AW-1:0] first_addr;

`ifdef STORE_PKT_HDR_WORD_EN
    logic [PKT_LEN_WIDTH-1:0] byte_len_q;
    logic [AW-1:0]            hdr_addr_q;
    logic [DATA_WIDTH-1:0]    hdr_data;

    always_comb begin
        hdr_data        = '0;
        hdr_data[15:0]  = 16'(byte_len_q);
        hdr_data[31:16] = 16'(word_cnt_q);
    end
    assign first_addr = wrap(dst_oq_wr_addr, dst_oq_low_addr, dst_oq_high_addr);
`else
    logic unused_byte_len;
    assign unused_byte_len = ^parsed_pkt_byte_len;
    assign first_addr      = dst_oq_wr_addr;
`endif

    assign acked       = wr_0_req & wr_0_ack;
    assign eop         = prev_ctrl_zero_q & (input_fifo_ctrl_out != '0);
    assign rd_dst_oq   = (state_q == StIdle) & dst_oq_avail;
    assign rd_dst_addr = (state_q == StReadAddr);
    assign need        = (AW + 1)'(word_len_q) + (AW + 1)'(HDR_WORDS);
    assign admit       = (32'(dst_oq) < NUM_OUTPUT_QUEUES) && (dst_oq_words_free >= need);
    assign input_fifo_rd_en = pop;

    always_comb begin
        pop = 1'b0;
        case (state_q)
            StLatch:            pop = admit & ~input_fifo_empty;
            StMove:             pop = acked & ~input_fifo_empty;
            StWaitData, StDrop: pop = ~input_fifo_empty;
            default:            pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q                <= StIdle;
            dst_oq                 <= '0;
            word_len_q             <= '0;
            lo_q                   <= '0;
            hi_q                   <= '0;
            next_addr_q            <= '0;
            word_cnt_q             <= '0;
            prev_ctrl_zero_q       <= 1'b0;
            dst_oq_wr_addr_new     <= '0;
            pkt_stored             <= 1'b0;
            pkt_dropped            <= 1'b0;
            pkt_len_err            <= 1'b0;
            stored_pkt_word_length <= '0;
            wr_0_addr              <= '0;
            wr_0_data              <= '0;
            wr_0_req               <= 1'b0;
`ifdef STORE_PKT_HDR_WORD_EN
            byte_len_q             <= '0;
            hdr_addr_q             <= '0;
`endif
        end else begin
            pkt_stored  <= 1'b0;
            pkt_dropped <= 1'b0;
            pkt_len_err <= 1'b0;
            if (pop) prev_ctrl_zero_q <= (input_fifo_ctrl_out == '0);
            case (state_q)
                StIdle: if (dst_oq_avail) begin
                    dst_oq     <= parsed_dst_oq;
                    word_len_q <= parsed_pkt_word_len;
`ifdef STORE_PKT_HDR_WORD_EN
                    byte_len_q <= parsed_pkt_byte_len;
`endif
                    state_q    <= StReadAddr;
                end
                StReadAddr: state_q <= StLatch;
                StLatch: begin
                    lo_q       <= dst_oq_low_addr;
                    hi_q       <= dst_oq_high_addr;
                    word_cnt_q <= '0;
                    if (!admit) begin
                        state_q <= StDrop;
                    end else begin
`ifdef STORE_PKT_HDR_WORD_EN
                        hdr_addr_q <= dst_oq_wr_addr;
`endif
                        if (pop) begin
                            wr_0_addr   <= first_addr;
                            wr_0_data   <= {input_fifo_ctrl_out, input_fifo_data_out};
                            wr_0_req    <= 1'b1;
                            next_addr_q <= wrap(first_addr, dst_oq_low_addr, dst_oq_high_addr);
                            word_cnt_q  <= WW'(1);
                            state_q     <= eop ? StTail : StMove;
                        end else begin
                            next_addr_q <= first_addr;
                            state_q     <= StWaitData;
                        end
                    end
                end
                StMove, StWaitData: begin
                    if (pop) begin
                        wr_0_addr   <= next_addr_q;
                        wr_0_data   <= {input_fifo_ctrl_out, input_fifo_data_out};
                        wr_0_req    <= 1'b1;
                        next_addr_q <= wrap(next_addr_q, lo_q, hi_q);
                        word_cnt_q  <= word_cnt_q + WW'(1);
                        state_q     <= eop ? StTail : StMove;
                    end else if (state_q == StMove && acked) begin
                        wr_0_req <= 1'b0;
                        state_q  <= StWaitData;
                    end
                end
`ifdef STORE_PKT_HDR_WORD_EN
                StTail: if (acked) begin
                    wr_0_addr <= hdr_addr_q;
                    wr_0_data <= {{CTRL_WIDTH{1'b1}}, hdr_data};
                    state_q   <= StHdr;
                end
                StHdr: if (acked) begin
`else
                StTail: if (acked) begin
`endif
                    // next_addr_q already holds wrap(last data address)
                    wr_0_req               <= 1'b0;
                    pkt_stored             <= 1'b1;
                    dst_oq_wr_addr_new     <= next_addr_q;
                    stored_pkt_word_length <= word_cnt_q + WW'(HDR_WORDS);
                    pkt_len_err            <= (word_cnt_q != {1'b0, word_len_q});
                    state_q                <= StIdle;
                end
                StDrop: if (pop && eop) begin
                    pkt_dropped <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_store_pkt_hdr.sv
// Scoreboard bench for store_pkt_hdr: stimulus queues expected SRAM writes and commit events,
// a per-cycle monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_store_pkt_hdr;

    localparam int DW = 64, CW = 8, AW = 19, QW = 3, LW = 11, WW = 8;
`ifdef STORE_PKT_HDR_WORD_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic dst_oq_avail;
    logic [QW-1:0] parsed_dst_oq;
    logic [LW-1:0] parsed_pkt_byte_len;
    logic [WW-1:0] parsed_pkt_word_len;
    logic rd_dst_oq, rd_dst_addr;
    logic [QW-1:0] dst_oq;
    logic [AW-1:0] dst_oq_wr_addr, dst_oq_low_addr, dst_oq_high_addr, dst_oq_wr_addr_new;
    logic [AW:0] dst_oq_words_free;
    logic pkt_stored, pkt_dropped, pkt_len_err;
    logic [WW:0] stored_pkt_word_length;
    logic [AW-1:0] wr_0_addr;
    logic [DW+CW-1:0] wr_0_data;
    logic wr_0_req, wr_0_ack;
    logic input_fifo_rd_en, input_fifo_empty;
    logic [DW-1:0] input_fifo_data_out;
    logic [CW-1:0] input_fifo_ctrl_out;

    store_pkt_hdr dut (
        .clk(clk), .reset(reset), .dst_oq_avail(dst_oq_avail), .parsed_dst_oq(parsed_dst_oq),
        .parsed_pkt_byte_len(parsed_pkt_byte_len), .parsed_pkt_word_len(parsed_pkt_word_len),
        .rd_dst_oq(rd_dst_oq), .dst_oq(dst_oq), .rd_dst_addr(rd_dst_addr),
        .dst_oq_wr_addr(dst_oq_wr_addr), .dst_oq_low_addr(dst_oq_low_addr),
        .dst_oq_high_addr(dst_oq_high_addr), .dst_oq_words_free(dst_oq_words_free),
        .dst_oq_wr_addr_new(dst_oq_wr_addr_new), .pkt_stored(pkt_stored),
        .pkt_dropped(pkt_dropped), .pkt_len_err(pkt_len_err),
        .stored_pkt_word_length(stored_pkt_word_length), .wr_0_addr(wr_0_addr),
        .wr_0_data(wr_0_data), .wr_0_req(wr_0_req), .wr_0_ack(wr_0_ack),
        .input_fifo_rd_en(input_fifo_rd_en), .input_fifo_empty(input_fifo_empty),
        .input_fifo_data_out(input_fifo_data_out), .input_fifo_ctrl_out(input_fifo_ctrl_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [AW-1:0] addr; logic [DW+CW-1:0] data;} wr_t;
    typedef struct packed {logic stored; logic [AW-1:0] ptr; logic [WW:0] len; logic err;} ev_t;

    logic [DW+CW-1:0] fq[$];
    wr_t exp_wr[$];
    ev_t exp_ev[$];

    int checks = 0, passed = 0;
    int wr_count = 0, ev_count = 0, pkt_pops = 0;
    int stall_at = -1, stall_left = 0;
    bit ack_toggle = 0, pop_pending = 0, stall = 0;
    logic prev_req = 0, prev_ack = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW+CW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [DW+CW-1:0] pw(input int i, input logic [DW-1:0] base);
        logic [CW-1:0] c;
        c = (i == 0) ? 8'hFF : (i == 3) ? 8'h40 : 8'h00;
        return {c, base + DW'(i)};
    endfunction

    function automatic logic [DW+CW-1:0] hdr(input int blen, input int cnt);
        return {8'hFF, 32'h0, 16'(cnt), 16'(blen)};
    endfunction

    task automatic fifo_refresh();
        input_fifo_empty = stall || (fq.size() == 0);
        if (fq.size() != 0) {input_fifo_ctrl_out, input_fifo_data_out} = fq[0];
        else {input_fifo_ctrl_out, input_fifo_data_out} = '0;
    endtask

    task automatic monitor();
        wr_t w;
        ev_t e;
        if (reset && prev_req && !prev_ack) begin
            check("hold_req", wr_0_req, 1'b1);
            check("hold_addr", wr_0_addr, prev_addr);
            check("hold_data", wr_0_data, prev_data);
        end
        if (wr_0_req && wr_0_ack) begin
            wr_count++;
            if (exp_wr.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected none", wr_0_addr,
                         wr_0_data);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", wr_0_addr, w.addr);
                check("wr_data", wr_0_data, w.data);
            end
        end
        if (pkt_stored || pkt_dropped) begin
            ev_count++;
            if (exp_ev.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event: stored %0b dropped %0b, expected none",
                         pkt_stored, pkt_dropped);
            end else begin
                e = exp_ev.pop_front();
                check("ev_stored", pkt_stored, e.stored);
                check("ev_dropped", pkt_dropped, !e.stored);
                check("ev_len_err", pkt_len_err, e.err);
                if (e.stored) begin
                    check("new_wr_ptr", dst_oq_wr_addr_new, e.ptr);
                    check("stored_len", stored_pkt_word_length, e.len);
                end
            end
        end
        prev_req  = wr_0_req;
        prev_ack  = wr_0_ack;
        prev_addr = wr_0_addr;
        prev_data = wr_0_data;
    endtask

    // FIFO model (first-word fall-through), ack pattern and monitor, one iteration per cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (pop_pending && fq.size() != 0) begin
                void'(fq.pop_front());
                pkt_pops++;
            end
            pop_pending = 0;
            #1;
            wr_0_ack = ack_toggle ? ~wr_0_ack : 1'b1;
            if (stall_left > 0 && pkt_pops == stall_at) begin
                stall = 1;
                stall_left--;
            end else begin
                stall = 0;
            end
            fifo_refresh();
            @(negedge clk);
            monitor();
            pop_pending = input_fifo_rd_en && !input_fifo_empty;
        end
    end

    task automatic send(input int oq, input int blen, input int wlen, input int lo, input int hi,
                        input int wr, input int fr, input bit timing, input bit wait_done);
        int n;
        bit seen;
        int ev0;
        ev0 = ev_count;
        @(posedge clk);
        #2;
        parsed_dst_oq       = QW'(oq);
        parsed_pkt_byte_len = LW'(blen);
        parsed_pkt_word_len = WW'(wlen);
        dst_oq_low_addr     = AW'(lo);
        dst_oq_high_addr    = AW'(hi);
        dst_oq_wr_addr      = AW'(wr);
        dst_oq_words_free   = (AW + 1)'(fr);
        dst_oq_avail        = 1'b1;
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (rd_dst_oq) seen = 1;
        end
        if (timing) check("rd_dst_oq_cycle0", n, 1);
        @(posedge clk);
        #2;
        dst_oq_avail = 1'b0;
        if (timing) begin
            @(negedge clk);
            check("rd_dst_addr_cycle1", rd_dst_addr, 1'b1);
            check("dst_oq_latched", dst_oq, QW'(oq));
            @(negedge clk);
            check("req_low_cycle2", wr_0_req, 1'b0);
            @(negedge clk);
            check("req_high_cycle3", wr_0_req, 1'b1);
        end
        if (wait_done) begin
            n = 0;
            while (ev_count == ev0 && n < 300) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (ev_count == ev0) begin
                checks++;
                $display("FAIL pkt_timeout: no commit or drop after %0d cycles, expected one", n);
            end
        end
    endtask

    // 4-word packet; a0..a3 are the hand-computed data addresses.
    task automatic run_pkt(input int wr, input int fr, input int wlen, input int blen,
                           input int a0, input int a1, input int a2, input int a3,
                           input int ptr, input bit admit, input bit err, input bit timing);
        int wc0;
        logic [DW-1:0] base;
        int a[4];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        base = DW'(wr) << 16;
        pkt_pops = 0;
        for (int i = 0; i < 4; i++) fq.push_back(pw(i, base));
        if (admit) begin
            for (int i = 0; i < 4; i++) exp_wr.push_back('{AW'(a[i]), pw(i, base)});
            if (H == 1) exp_wr.push_back('{AW'(wr), hdr(blen, 4)});
            exp_ev.push_back('{1'b1, AW'(ptr), (WW + 1)'(4 + H), err});
        end else begin
            exp_ev.push_back('{1'b0, AW'(0), (WW + 1)'(0), 1'b0});
        end
        wc0 = wr_count;
        send(2, blen, wlen, 'h100, 'h1FF, wr, fr, timing, 1'b1);
        check("write_count", wr_count - wc0, admit ? 4 + H : 0);
        check("fifo_drained", fq.size(), 0);
        check("writes_left", exp_wr.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wc0, ev0, n;
        logic [DW-1:0] base;
        reset = 1'b0;
        dst_oq_avail = 1'b0;
        parsed_dst_oq = '0;
        parsed_pkt_byte_len = '0;
        parsed_pkt_word_len = '0;
        dst_oq_wr_addr = '0;
        dst_oq_low_addr = '0;
        dst_oq_high_addr = '0;
        dst_oq_words_free = '0;
        wr_0_ack = 1'b1;
        input_fifo_empty = 1'b1;
        input_fifo_data_out = '0;
        input_fifo_ctrl_out = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_0_req", wr_0_req, 1'b0);
        check("rst_rd_en", input_fifo_rd_en, 1'b0);
        check("rst_rd_dst_addr", rd_dst_addr, 1'b0);
        check("rst_pkt_stored", pkt_stored, 1'b0);
        check("rst_wr_addr_new", dst_oq_wr_addr_new, '0);
        check("rst_stored_len", stored_pkt_word_length, '0);
        check("rst_wr_0_addr", wr_0_addr, '0);
        @(posedge clk);
        #2 reset = 1'b1;

        // basic store, with the cycle-by-cycle handshake latency checked
        run_pkt('h120, 100, 4, 32, 'h120 + H, 'h121 + H, 'h122 + H, 'h123 + H, 'h124 + H,
                1, 0, 1);
        // wrap across hi
`ifdef STORE_PKT_HDR_WORD_EN
        run_pkt('h1FE, 100, 4, 32, 'h1FF, 'h100, 'h101, 'h102, 'h103, 1, 0, 0);
        run_pkt('h1FF, 100, 4, 32, 'h100, 'h101, 'h102, 'h103, 'h104, 1, 0, 0);
`else
        run_pkt('h1FE, 100, 4, 32, 'h1FE, 'h1FF, 'h100, 'h101, 'h102, 1, 0, 0);
        run_pkt('h1FF, 100, 4, 32, 'h1FF, 'h100, 'h101, 'h102, 'h103, 1, 0, 0);
`endif
        // one word short of room: dropped; exactly enough room: stored
        run_pkt('h130, 3 + H, 4, 32, 0, 0, 0, 0, 0, 0, 0, 0);
        run_pkt('h130, 4 + H, 4, 32, 'h130 + H, 'h131 + H, 'h132 + H, 'h133 + H, 'h134 + H,
                1, 0, 0);
        // FIFO stalls 3 cycles after two pops while ack toggles
        ack_toggle = 1;
        stall_at = 2;
        stall_left = 3;
        run_pkt('h150, 100, 4, 32, 'h150 + H, 'h151 + H, 'h152 + H, 'h153 + H, 'h154 + H,
                1, 0, 0);
        ack_toggle = 0;
        stall_at = -1;
        stall_left = 0;
        // parsed length 5, actual 4
        run_pkt('h160, 100, 5, 40, 'h160 + H, 'h161 + H, 'h162 + H, 'h163 + H, 'h164 + H,
                1, 1, 0);

        // reset mid-packet after the 2nd data ack
        base = DW'('h170) << 16;
        pkt_pops = 0;
        for (int i = 0; i < 4; i++) fq.push_back(pw(i, base));
        for (int i = 0; i < 4; i++) exp_wr.push_back('{AW'('h170 + H + i), pw(i, base)});
        wc0 = wr_count;
        ev0 = ev_count;
        send(2, 32, 4, 'h100, 'h1FF, 'h170, 100, 1'b0, 1'b0);
        n = 0;
        while (wr_count < wc0 + 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_two_acks", wr_count - wc0, 2);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_req", wr_0_req, 1'b0);
        check("rst_mid_rd_en", input_fifo_rd_en, 1'b0);
        exp_wr.delete();
        fq.delete();
        pop_pending = 0;
        fifo_refresh();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("rst_no_commit", ev_count - ev0, 0);
        run_pkt('h180, 100, 4, 32, 'h180 + H, 'h181 + H, 'h182 + H, 'h183 + H, 'h184 + H,
                1, 0, 0);

        repeat (3) @(negedge clk);
        check("events_left", exp_ev.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
